// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache.
// Holds the default geometry, the derived address-field widths and the
// controller state encoding, plus a byte-lane merge helper.
package dcache_pkg;

  localparam int unsigned DC_LINES   = 16;
  localparam int unsigned DC_WORDS   = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = DATA_W / 8;
  localparam int unsigned BYTE_OFF_W = 2;

  // Address split at the default geometry: | tag | index | word | byte |
  localparam int unsigned OFFSET_W = $clog2(DC_WORDS);
  localparam int unsigned INDEX_W  = $clog2(DC_LINES);
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W - BYTE_OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (be[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Cache data storage: LINES x WORDS x 32-bit words.
// Ports:
//   clk      - clock, writes on rising edge
//   i_we     - byte write enables (4'b0000 = no write)
//   i_wline  - line index of the write
//   i_wword  - word within the line of the write
//   i_wdata  - write data, only enabled bytes are stored
//   i_rline  - line index of the combinational read
//   i_rword  - word within the line of the combinational read
//   o_rdata  - read data
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = DC_LINES,
  parameter int unsigned WORDS = DC_WORDS,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned OFF_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   i_we,
  input  logic [IDX_W-1:0]  i_wline,
  input  logic [OFF_W-1:0]  i_wword,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_rline,
  input  logic [OFF_W-1:0]  i_rword,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [LINES][WORDS];

  // Byte-enabled write; contents are not reset.
  always_ff @(posedge clk) begin
    if (|i_we) begin
      r_mem[i_wline][i_wword] <= byte_merge(r_mem[i_wline][i_wword], i_wdata, i_we);
    end
  end

  assign o_rdata = r_mem[i_rline][i_rword];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read misses refill a whole line from the backing RAM one word per cycle.
// Ports:
//   clk, resetn         - clock and synchronous active-low reset
//   cpu_req/addr/wen/wdata - CPU access request (wen == 0 means read)
//   cpu_ready           - request can be accepted this cycle (IDLE only)
//   cpu_ack, cpu_rdata  - one-cycle completion pulse and load data
//   mem_addr/wen/wdata  - backing RAM port (write-through and refill reads)
//   mem_rdata           - backing RAM read data, one cycle after mem_addr
//   flush               - invalidate all lines when idle and no request
//   hit_cnt, miss_cnt   - read hit / read miss counters
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = DC_LINES,
  parameter int unsigned WORDS = DC_WORDS
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BE_W-1:0]   cpu_wen,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int unsigned L_OFF_W = $clog2(WORDS);
  localparam int unsigned L_IDX_W = $clog2(LINES);
  localparam int unsigned L_TAG_W = ADDR_W - L_IDX_W - L_OFF_W - BYTE_OFF_W;
  // Refill counter runs 0..WORDS inclusive.
  localparam int unsigned CNT_W   = $clog2(WORDS + 1);

  state_t               r_state;
  state_t               w_next_state;

  logic [ADDR_W-1:0]    r_addr;
  logic [BE_W-1:0]      r_wen;
  logic [DATA_W-1:0]    r_wdata;
  logic [CNT_W-1:0]     r_cnt;
  logic [LINES-1:0]     r_valid;
  logic [L_TAG_W-1:0]   r_tag [LINES];
  logic [31:0]          r_hit_cnt;
  logic [31:0]          r_miss_cnt;
  logic [ADDR_W-1:0]    r_mem_addr;

  logic [L_TAG_W-1:0]   w_tag;
  logic [L_IDX_W-1:0]   w_index;
  logic [L_OFF_W-1:0]   w_word;
  logic                 w_hit;
  logic                 w_is_write;
  logic                 w_refill_done;
  logic                 w_accept;
  logic                 w_flush_now;
  logic                 w_mem_drive;
  logic [ADDR_W-1:0]    w_mem_addr;
  logic [BE_W-1:0]      w_mem_wen;
  logic [DATA_W-1:0]    w_mem_wdata;
  logic [BE_W-1:0]      w_arr_we;
  logic [L_OFF_W-1:0]   w_arr_word;
  logic [DATA_W-1:0]    w_arr_wdata;
  logic [DATA_W-1:0]    w_arr_rdata;
  logic                 w_unused;

  // Fields of the latched request address; byte offset is ignored.
  assign w_tag      = r_addr[ADDR_W-1 -: L_TAG_W];
  assign w_index    = r_addr[BYTE_OFF_W + L_OFF_W +: L_IDX_W];
  assign w_word     = r_addr[BYTE_OFF_W +: L_OFF_W];
  assign w_unused   = &{1'b0, r_addr[BYTE_OFF_W-1:0]};

  assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_is_write    = |r_wen;
  assign w_accept      = (r_state == ST_IDLE) && cpu_req;
  assign w_flush_now   = (r_state == ST_IDLE) && flush && !cpu_req;
  assign w_refill_done = (r_state == ST_REFILL) && (r_cnt == CNT_W'(WORDS));

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (cpu_req) w_next_state = ST_LOOKUP;
      ST_LOOKUP: w_next_state = (w_is_write || w_hit) ? ST_IDLE : ST_REFILL;
      ST_REFILL: if (w_refill_done) w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Output / datapath control decode.
  always_comb begin
    cpu_ready   = 1'b0;
    cpu_ack     = 1'b0;
    w_mem_drive = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wen   = '0;
    w_mem_wdata = r_wdata;
    w_arr_we    = '0;
    w_arr_word  = w_word;
    w_arr_wdata = r_wdata;
    case (r_state)
      ST_IDLE: cpu_ready = 1'b1;
      ST_LOOKUP: begin
        if (w_is_write) begin
          // Write-through always; update the cached copy only on a hit.
          cpu_ack     = 1'b1;
          w_mem_drive = 1'b1;
          w_mem_addr  = {r_addr[ADDR_W-1:BYTE_OFF_W], 2'b00};
          w_mem_wen   = r_wen;
          if (w_hit) w_arr_we = r_wen;
        end else if (w_hit) begin
          cpu_ack = 1'b1;
        end
      end
      ST_REFILL: begin
        // Address word k while storing the word fetched for k-1.
        if (r_cnt < CNT_W'(WORDS)) begin
          w_mem_drive = 1'b1;
          w_mem_addr  = {w_tag, w_index, L_OFF_W'(r_cnt), 2'b00};
        end
        if (r_cnt != '0) begin
          w_arr_we    = '1;
          w_arr_word  = L_OFF_W'(r_cnt - CNT_W'(1));
          w_arr_wdata = mem_rdata;
        end
      end
      ST_RESP: cpu_ack = 1'b1;
      default: ;
    endcase
  end

  assign cpu_rdata = w_arr_rdata;
  assign mem_addr  = w_mem_addr;
  assign mem_wen   = w_mem_wen;
  assign mem_wdata = w_mem_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // Reset-covered control state: valid bits, refill counter, statistics.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid    <= '0;
      r_cnt      <= '0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_mem_addr <= '0;
    end else begin
      if (w_mem_drive) r_mem_addr <= w_mem_addr;
      if ((r_state == ST_LOOKUP) && !w_is_write) begin
        if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
        else       r_miss_cnt <= r_miss_cnt + 32'd1;
        r_cnt <= '0;
      end else if (r_state == ST_REFILL) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_refill_done)    r_valid[w_index] <= 1'b1;
      else if (w_flush_now) r_valid          <= '0;
    end
  end

  // Request latch and tag store; neither needs reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= cpu_addr;
      r_wen   <= cpu_wen;
      r_wdata <= cpu_wdata;
    end
    if (w_refill_done) r_tag[w_index] <= w_tag;
  end

  dcache_data_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_data (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_wline (w_index),
    .i_wword (w_arr_word),
    .i_wdata (w_arr_wdata),
    .i_rline (w_index),
    .i_rword (w_word),
    .o_rdata (w_arr_rdata)
  );

endmodule

// File: tb/tb_dcache.sv
// Bench for dcache: a word-level reference memory plus a tag/valid model
// predict hit/miss, ack timing, load data and RAM traffic; a per-cycle
// compare checks the DUT, and literal expectations pin the model.
module tb_dcache;

  localparam int TB_WORDS = 4;
  localparam int TB_LINES = 16;
  localparam int RAM_WORDS = 256;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dcache dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wen   (cpu_wen),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .flush     (flush),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // Backing RAM driven by the DUT, and the reference memory image.
  logic [31:0] ram     [RAM_WORDS];
  logic [31:0] ref_mem [RAM_WORDS];
  // Which tag each line holds, as far as the model knows.
  bit          mvalid  [TB_LINES];
  int          mtag    [TB_LINES];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Outstanding-request expectations.
  bit          exp_busy = 0;
  bit          exp_write;
  bit          exp_miss;
  int          exp_issue_cyc;
  int          exp_ack_cyc;
  logic [31:0] exp_rdata;
  logic [31:0] exp_addr;
  logic [3:0]  exp_wen;
  logic [31:0] exp_wdata;
  logic [31:0] exp_base;
  int          exp_hit_inc;
  int          exp_miss_inc;
  int          c_hits   = 0;
  int          c_misses = 0;
  int          obs_lat;
  logic [31:0] obs_rdata;

  logic [31:0] s_addr;
  logic [3:0]  s_wen;
  logic [31:0] s_wdata;

  function automatic logic [31:0] init_word(input int i);
    if (i >= 16 && i < 20) return 32'h11111111 * 32'(i - 15);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  task automatic compare();
    int k;
    if (!resetn) return;
    chk("cpu_ready", 32'(cpu_ready), (exp_busy && cyc > exp_issue_cyc) ? 32'd0 : 32'd1);
    if (exp_busy && cyc == exp_ack_cyc) begin
      chk("cpu_ack", 32'(cpu_ack), 32'd1);
      if (exp_write) begin
        chk("mem_wen_wr", 32'(mem_wen), 32'(exp_wen));
        chk("mem_addr_wr", mem_addr, exp_addr);
        chk("mem_wdata_wr", mem_wdata, exp_wdata);
      end else begin
        chk("cpu_rdata", cpu_rdata, exp_rdata);
        chk("mem_wen_rd", 32'(mem_wen), 32'd0);
      end
      obs_lat   = cyc - exp_issue_cyc;
      obs_rdata = cpu_rdata;
      c_hits   += exp_hit_inc;
      c_misses += exp_miss_inc;
      exp_busy  = 0;
    end else begin
      chk("cpu_ack_quiet", 32'(cpu_ack), 32'd0);
      chk("mem_wen_quiet", 32'(mem_wen), 32'd0);
      if (exp_busy && exp_miss) begin
        k = cyc - exp_issue_cyc - 2;
        if (k >= 0 && k < TB_WORDS) chk("refill_addr", mem_addr, exp_base + 32'(k * 4));
      end
      if (!exp_busy || cyc == exp_issue_cyc) begin
        chk("hit_cnt", hit_cnt, 32'(c_hits));
        chk("miss_cnt", miss_cnt, 32'(c_misses));
      end
    end
  endtask

  // One clock cycle: compare mid-cycle, then update the backing RAM.
  task automatic step();
    @(negedge clk);
    compare();
    s_addr  = mem_addr;
    s_wen   = mem_wen;
    s_wdata = mem_wdata;
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = ram[s_addr[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (s_wen[b]) ram[s_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TB_LINES; i++) mvalid[i] = 0;
    c_hits   = 0;
    c_misses = 0;
    exp_busy = 0;
  endtask

  // Issue one access, predict its outcome, and run until it completes.
  // reset_at > 0 pulses resetn in the cycle issue+reset_at.
  task automatic access(input logic [31:0] a, input logic [3:0] wen, input logic [31:0] wd,
                        input bit with_flush, input int reset_at);
    int idx;
    int tag;
    bit hit;
    idx = int'(a >> 4) % TB_LINES;
    tag = int'(a >> 8);
    hit = mvalid[idx] && (mtag[idx] == tag);
    exp_write     = (wen != 4'b0000);
    exp_miss      = 0;
    exp_issue_cyc = cyc;
    exp_hit_inc   = 0;
    exp_miss_inc  = 0;
    exp_addr      = a;
    exp_wen       = wen;
    exp_wdata     = wd;
    obs_lat       = -1;
    obs_rdata     = 32'hBAD0BAD0;
    if (exp_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wen[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
      end
      exp_ack_cyc = cyc + 1;
    end else if (hit) begin
      exp_rdata   = ref_mem[a[9:2]];
      exp_ack_cyc = cyc + 1;
      exp_hit_inc = 1;
    end else begin
      exp_rdata    = ref_mem[a[9:2]];
      exp_ack_cyc  = cyc + 3 + TB_WORDS;
      exp_miss     = 1;
      exp_miss_inc = 1;
      exp_base     = a & ~32'hF;
      mvalid[idx]  = 1;
      mtag[idx]    = tag;
    end
    cpu_req   = 1'b1;
    cpu_addr  = a;
    cpu_wen   = wen;
    cpu_wdata = wd;
    flush     = with_flush;
    exp_busy  = 1;
    step();
    cpu_req = 1'b0;
    cpu_wen = 4'b0000;
    flush   = 1'b0;
    for (int i = 0; i < 20 && exp_busy; i++) begin
      if (reset_at > 0 && cyc == exp_issue_cyc + reset_at) begin
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        model_reset();
      end else begin
        step();
      end
    end
    if (exp_busy) begin
      n_checks++;
      $display("FAIL ack_timeout: no ack for addr 0x%08h, expected at cycle %0d", a, exp_ack_cyc);
      exp_busy = 0;
    end
  endtask

  task automatic rd(input logic [31:0] a, input int lat, input logic [31:0] data);
    access(a, 4'b0000, 32'h0, 1'b0, 0);
    chk("lit_lat", 32'(obs_lat), 32'(lat));
    chk("lit_rdata", obs_rdata, data);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < TB_LINES; i++) mvalid[i] = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetn    = 1'b0;
    cpu_req   = 1'b0;
    cpu_addr  = '0;
    cpu_wen   = '0;
    cpu_wdata = '0;
    flush     = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < RAM_WORDS; i++) begin
      ram[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    model_reset();
    repeat (3) step();
    resetn = 1'b1;
    step();

    // Reset state.
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_hit", hit_cnt, 32'd0);
    chk("rst_miss", miss_cnt, 32'd0);
    chk("rst_mem_wen", 32'(mem_wen), 32'd0);

    // Cold miss, then hit in the refilled line.
    rd(32'h40, 7, 32'h11111111);
    chk("lit_miss1", miss_cnt, 32'd1);
    rd(32'h48, 1, 32'h33333333);
    chk("lit_hit1", hit_cnt, 32'd1);

    // Partial write hit, visible to the next read hit.
    access(32'h44, 4'b0011, 32'hAAAABBBB, 1'b0, 0);
    chk("lit_wr_lat", 32'(obs_lat), 32'd1);
    rd(32'h44, 1, 32'h2222BBBB);

    // Write miss goes to RAM only; the read that follows misses and sees it.
    access(32'h200, 4'b1111, 32'h12345678, 1'b0, 0);
    rd(32'h200, 7, 32'h12345678);

    // Conflict on index 4: replacement, then re-miss; write-through data survives.
    rd(32'h140, 7, 32'hC0DE0050);
    rd(32'h40, 7, 32'h11111111);
    rd(32'h44, 1, 32'h2222BBBB);

    // Reset during refill k=2: dropped without ack, everything invalid.
    access(32'h140, 4'b0000, 32'h0, 1'b0, 4);
    chk("lit_rst_noack", 32'(obs_lat), 32'hFFFFFFFF);
    chk("lit_rst_ready", 32'(cpu_ready), 32'd1);
    chk("lit_rst_hit", hit_cnt, 32'd0);
    chk("lit_rst_miss", miss_cnt, 32'd0);
    repeat (4) step();
    rd(32'h40, 7, 32'h11111111);

    // Flush invalidates all lines.
    rd(32'h80, 7, 32'hC0DE0020);
    rd(32'h48, 1, 32'h33333333);
    do_flush();
    rd(32'h48, 7, 32'h33333333);
    rd(32'h80, 7, 32'hC0DE0020);

    // Flush coinciding with a request is ignored.
    access(32'h84, 4'b0000, 32'h0, 1'b1, 0);
    chk("lit_flushreq_lat", 32'(obs_lat), 32'd1);
    chk("lit_flushreq_data", obs_rdata, 32'hC0DE0021);
    rd(32'h48, 1, 32'h33333333);

    // Single high-byte write hit.
    access(32'h88, 4'b1000, 32'hDEADBEEF, 1'b0, 0);
    rd(32'h88, 1, 32'hDEDE0022);

    step();
    chk("lit_final_hit", hit_cnt, 32'd4);
    chk("lit_final_miss", miss_cnt, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
